// File: rtl/mb_bus_cycle.sv
// Sequences one Amiga-side 68000 bus cycle for each decoded motherboard access from the
// accelerator CPU. The cycle ends on DTACK, 6800 DTACK, BERR, timeout or a CPU abort.
module mb_bus_cycle #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic C7M,
  input  logic RESET_n,
  input  logic AS_CPU_n,
  input  logic RW_CPU,
  input  logic UDS_CPU_n,
  input  logic LDS_CPU_n,
  input  logic SEL_MB,
  input  logic DTACK_MB_n,
  input  logic M6800_DTACK_n,
  input  logic BERR_MB_n,
  output logic AS_MB_n,
  output logic UDS_MB_n,
  output logic LDS_MB_n,
  output logic RW_MB,
  output logic OE_DATA_n,
  output logic LATCH_DATA,
  output logic DTACK_CPU_n,
  output logic BERR_CPU_n,
  output logic BUSY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DS   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_TERM = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;
  localparam logic [2:0] S_REC  = 3'd6;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_as_sync;
  logic                   w_as_s;
  logic [2:0]             r_state;
  logic [2:0]             w_state_d;
  logic [7:0]             r_count;
  logic [7:0]             w_count_d;
  logic                   r_err;
  logic                   w_err_d;
  logic                   r_rw;
  logic                   r_uds;
  logic                   r_lds;
  logic                   w_start;

  // Synchroniser idles high so a reset never looks like a pending access.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) r_as_sync <= '1;
    else          r_as_sync <= {r_as_sync[SYNC_STAGES-2:0], AS_CPU_n};
  end

  assign w_as_s  = r_as_sync[SYNC_STAGES-1];
  assign w_start = (r_state == S_IDLE) && !w_as_s && SEL_MB;

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_err_d   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_d = S_ADDR;
          w_count_d = '0;
          w_err_d   = 1'b0;
        end
      end
      S_ADDR: w_state_d = w_as_s ? S_REC : S_DS;
      S_DS:   w_state_d = w_as_s ? S_REC : S_WAIT;
      S_WAIT: begin
        // Bus error outranks any acknowledge arriving on the same edge.
        if (w_as_s) begin
          w_state_d = S_REC;
        end else if (!BERR_MB_n) begin
          w_state_d = S_TERM;
          w_err_d   = 1'b1;
        end else if (!DTACK_MB_n || !M6800_DTACK_n) begin
          w_state_d = S_TERM;
          w_err_d   = 1'b0;
        end else if (r_count == TIMEOUT_LAST) begin
          w_state_d = S_TERM;
          w_err_d   = 1'b1;
        end else begin
          w_count_d = r_count + 8'd1;
        end
      end
      S_TERM: w_state_d = S_ACK;
      S_ACK:  if (w_as_s) w_state_d = S_REC;
      S_REC:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
      r_rw    <= 1'b1;
      r_uds   <= 1'b1;
      r_lds   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_err   <= w_err_d;
      if (w_start) begin
        r_rw  <= RW_CPU;
        r_uds <= UDS_CPU_n;
        r_lds <= LDS_CPU_n;
      end
    end
  end

  // Outputs decode registered state only, so input changes never reach the bus directly.
  always_comb begin
    AS_MB_n     = 1'b1;
    UDS_MB_n    = 1'b1;
    LDS_MB_n    = 1'b1;
    RW_MB       = 1'b1;
    OE_DATA_n   = 1'b1;
    LATCH_DATA  = 1'b0;
    DTACK_CPU_n = 1'b1;
    BERR_CPU_n  = 1'b1;
    case (r_state)
      S_ADDR: begin
        AS_MB_n   = 1'b0;
        RW_MB     = r_rw;
        OE_DATA_n = 1'b0;
        if (r_rw) begin
          UDS_MB_n = r_uds;
          LDS_MB_n = r_lds;
        end
      end
      S_DS, S_WAIT, S_TERM: begin
        AS_MB_n    = 1'b0;
        RW_MB      = r_rw;
        OE_DATA_n  = 1'b0;
        UDS_MB_n   = r_uds;
        LDS_MB_n   = r_lds;
        LATCH_DATA = (r_state == S_TERM) && r_rw && !r_err;
      end
      S_ACK: begin
        RW_MB       = r_rw;
        OE_DATA_n   = 1'b0;
        DTACK_CPU_n = r_err;
        BERR_CPU_n  = !r_err;
      end
      default: ;
    endcase
  end

  assign BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_mb_bus_cycle.sv
// Scoreboard bench for mb_bus_cycle: the driver pushes the expected cycle outcome, a
// monitor reconstructs each motherboard cycle from the bus pins and compares.
module tb_mb_bus_cycle;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 16;

  logic C7M = 1'b0;
  logic RESET_n, AS_CPU_n, RW_CPU, UDS_CPU_n, LDS_CPU_n, SEL_MB;
  logic DTACK_MB_n, M6800_DTACK_n, BERR_MB_n;
  logic AS_MB_n, UDS_MB_n, LDS_MB_n, RW_MB, OE_DATA_n, LATCH_DATA;
  logic DTACK_CPU_n, BERR_CPU_n, BUSY;

  mb_bus_cycle #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .C7M          (C7M),
    .RESET_n      (RESET_n),
    .AS_CPU_n     (AS_CPU_n),
    .RW_CPU       (RW_CPU),
    .UDS_CPU_n    (UDS_CPU_n),
    .LDS_CPU_n    (LDS_CPU_n),
    .SEL_MB       (SEL_MB),
    .DTACK_MB_n   (DTACK_MB_n),
    .M6800_DTACK_n(M6800_DTACK_n),
    .BERR_MB_n    (BERR_MB_n),
    .AS_MB_n      (AS_MB_n),
    .UDS_MB_n     (UDS_MB_n),
    .LDS_MB_n     (LDS_MB_n),
    .RW_MB        (RW_MB),
    .OE_DATA_n    (OE_DATA_n),
    .LATCH_DATA   (LATCH_DATA),
    .DTACK_CPU_n  (DTACK_CPU_n),
    .BERR_CPU_n   (BERR_CPU_n),
    .BUSY         (BUSY)
  );

  always #5 C7M = ~C7M;

  // Response kinds driven by the bench's motherboard model.
  localparam int K_DTACK = 0, K_M6800 = 1, K_BERR = 2, K_BOTH = 3, K_NONE = 4,
                 K_ABORT = 5, K_NOSEL = 6, K_RESET = 7;

  typedef struct {
    logic rw, uds, lds, err, abort;
    int   t;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0, n_total = 0;

  int         m_phase = 0, m_n = 0, m_nlatch = 0, m_latch_n = 0;
  logic       m_rw;
  logic [1:0] m_s0, m_s1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Edges are numbered from E0, the edge that starts the motherboard cycle. A line driven
  // after E_j is first seen at E_(j+1); the wait phase samples at E3 onward, and the
  // timeout fires on the TIMEOUT-th wait edge, E_(TIMEOUT+2).
  function automatic exp_t model(input int kind, input int j, input logic rw,
                                 input logic uds, input logic lds);
    exp_t e;
    int dt = 1000, be = 1000, to = TIMEOUT + 2, t;
    e.rw = rw; e.uds = uds; e.lds = lds; e.abort = 1'b0;
    if (kind == K_DTACK || kind == K_BOTH) dt = (j + 1 < 3) ? 3 : j + 1;
    if (kind == K_M6800) dt = j + 1;
    if (kind == K_BERR || kind == K_BOTH) be = (j + 1 < 3) ? 3 : j + 1;
    t = dt;
    if (be < t) t = be;
    if (to < t) t = to;
    e.err = (be == t) || (dt != t);
    e.t   = t;
    if (kind == K_ABORT) begin
      e.abort = 1'b1;
      e.err   = 1'b0;
      e.t     = j + SYNC + 1;
    end
    return e;
  endfunction

  task automatic finish_txn(input bit aborted);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("abort_kind", aborted, e.abort);
    check("end_edge", m_n, e.abort ? e.t : e.t + 1);
    check("rw_mb", m_rw, e.rw);
    check("strobe_addr", m_s0, e.rw ? {e.uds, e.lds} : 2'b11);
    check("strobe_ds", m_s1, {e.uds, e.lds});
    check("latch_cnt", m_nlatch, (e.rw && !e.err && !e.abort) ? 1 : 0);
    if (m_nlatch == 1) check("latch_edge", m_latch_n, e.t);
    if (e.abort) begin
      check("abort_noack", {DTACK_CPU_n, BERR_CPU_n}, 2'b11);
    end else begin
      check("ack_kind", {DTACK_CPU_n, BERR_CPU_n}, e.err ? 2'b10 : 2'b01);
      check("ack_release", {AS_MB_n, UDS_MB_n, LDS_MB_n}, 3'b111);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge C7M);
      if (!RESET_n) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (!AS_MB_n) begin
          m_phase = 1; m_n = 0; m_nlatch = 0; m_latch_n = 0;
          m_rw = RW_MB; m_s0 = {UDS_MB_n, LDS_MB_n};
        end
      end else if (m_phase == 1) begin
        m_n++;
        if (m_n == 1) m_s1 = {UDS_MB_n, LDS_MB_n};
        if (LATCH_DATA) begin
          m_nlatch++;
          m_latch_n = m_n;
        end
        if (!DTACK_CPU_n || !BERR_CPU_n) begin
          finish_txn(1'b0);
          m_phase = 2;
        end else if (AS_MB_n) begin
          finish_txn(1'b1);
          m_phase = 2;
        end
      end else if (!BUSY) begin
        m_phase = 0;
      end
    end
  end

  task automatic run_txn(input int kind, input int j, input logic rw, input logic uds,
                         input logic lds);
    int cnt, n;
    @(negedge C7M);
    RW_CPU = rw; UDS_CPU_n = uds; LDS_CPU_n = lds; SEL_MB = (kind != K_NOSEL);
    AS_CPU_n = 1'b0;
    if (kind == K_NOSEL) begin
      repeat (8) @(negedge C7M);
      check("nosel_as", AS_MB_n, 1'b1);
      check("nosel_busy", BUSY, 1'b0);
      AS_CPU_n = 1'b1;
      repeat (2) @(negedge C7M);
      return;
    end
    if (kind != K_RESET) sb_q.push_back(model(kind, j, rw, uds, lds));
    cnt = 0;
    while (AS_MB_n && cnt < 10) begin
      @(negedge C7M);
      cnt++;
    end
    check("as_latency", cnt, SYNC + 1);
    if (kind == K_RESET) begin
      repeat (5) @(negedge C7M);
      #2 RESET_n = 1'b0;
      #1 check("rst_async", {AS_MB_n, UDS_MB_n, LDS_MB_n, RW_MB, OE_DATA_n, LATCH_DATA,
                             DTACK_CPU_n, BERR_CPU_n, BUSY}, 9'b111110110);
      AS_CPU_n = 1'b1;
      @(negedge C7M);
      #2 RESET_n = 1'b1;
      repeat (2) @(negedge C7M);
      return;
    end
    n = 0;
    forever begin
      if (n == j) begin
        case (kind)
          K_DTACK: DTACK_MB_n = 1'b0;
          K_M6800: M6800_DTACK_n = 1'b0;
          K_BERR:  BERR_MB_n = 1'b0;
          K_BOTH:  begin DTACK_MB_n = 1'b0; BERR_MB_n = 1'b0; end
          K_ABORT: AS_CPU_n = 1'b1;
          default: ;
        endcase
      end
      if (kind == K_M6800 && n == j + 1) M6800_DTACK_n = 1'b1;
      @(negedge C7M);
      n++;
      if (!DTACK_CPU_n || !BERR_CPU_n || (kind == K_ABORT && AS_MB_n) || n > 100) break;
    end
    check("cycle_end_seen", (n > 100) ? 0 : 1, 1);
    AS_CPU_n = 1'b1; DTACK_MB_n = 1'b1; BERR_MB_n = 1'b1; M6800_DTACK_n = 1'b1;
    if (kind == K_ABORT) begin
      @(negedge C7M);
      check("abort_idle", BUSY, 1'b0);
      return;
    end
    repeat (2) @(negedge C7M);
    check("ack_hold", DTACK_CPU_n & BERR_CPU_n, 1'b0);
    @(negedge C7M);
    check("rec_state", {DTACK_CPU_n, BERR_CPU_n, OE_DATA_n, BUSY}, 4'b1111);
    @(negedge C7M);
    check("idle_busy", BUSY, 1'b0);
  endtask

  initial begin : driver
    int kind, j, bm, guard;
    logic rw, uds, lds;
    RESET_n = 1'b0; AS_CPU_n = 1'b1; RW_CPU = 1'b1; UDS_CPU_n = 1'b1; LDS_CPU_n = 1'b1;
    SEL_MB = 1'b0; DTACK_MB_n = 1'b1; M6800_DTACK_n = 1'b1; BERR_MB_n = 1'b1;
    repeat (3) @(negedge C7M);
    check("reset_state", {AS_MB_n, UDS_MB_n, LDS_MB_n, RW_MB, OE_DATA_n, LATCH_DATA,
                          DTACK_CPU_n, BERR_CPU_n, BUSY}, 9'b111110110);
    RESET_n = 1'b1;
    repeat (2) @(negedge C7M);

    run_txn(K_DTACK, 0, 1'b1, 1'b0, 1'b0);   // word read, DTACK already low
    run_txn(K_DTACK, 6, 1'b0, 1'b0, 1'b1);   // UDS-only write, late DTACK
    run_txn(K_M6800, 11, 1'b1, 1'b1, 1'b0);  // 6800 pulse seen at E12
    run_txn(K_NONE, 0, 1'b1, 1'b0, 1'b0);    // timeout
    run_txn(K_BOTH, 4, 1'b1, 1'b0, 1'b0);    // BERR beats DTACK
    run_txn(K_RESET, 0, 1'b1, 1'b0, 1'b0);   // async reset mid-wait
    run_txn(K_DTACK, 2, 1'b1, 1'b0, 1'b0);   // normal cycle after reset
    run_txn(K_DTACK, TIMEOUT + 1, 1'b1, 1'b0, 1'b0);  // DTACK on the timeout edge
    run_txn(K_ABORT, 1, 1'b1, 1'b0, 1'b0);
    run_txn(K_NOSEL, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        K_M6800: j = $urandom_range(2, 20);
        K_ABORT: j = $urandom_range(0, 3);
        default: j = $urandom_range(0, 20);
      endcase
      rw = 1'($urandom_range(0, 1));
      bm = $urandom_range(0, 2);
      uds = (bm == 2);
      lds = (bm == 1);
      run_txn(kind, j, rw, uds, lds);
      repeat ($urandom_range(0, 3)) @(negedge C7M);
    end

    guard = 0;
    while ((sb_q.size() != 0 || m_phase != 0) && guard < 200) begin
      @(negedge C7M);
      guard++;
    end
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
